// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared encodings for the fetch PC sequencer: redirect target select and FSM states.
package fetch_pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_REG = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_sequencer_pc_target_calc.sv
// Combinational redirect target: sequential, PC-relative branch/jump, or register-indirect.
module pc_target_calc
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int AddrWidth   = 10,
  parameter int InstBytes   = 4,
  parameter int BrImmWidth  = 14,
  parameter int JmpImmWidth = 24
) (
  input  pc_sel_e                i_sel,
  input  logic [AddrWidth-1:0]   i_base,
  input  logic [BrImmWidth-1:0]  i_imm_br,
  input  logic [JmpImmWidth-1:0] i_imm_jmp,
  input  logic [AddrWidth-2:0]   i_reg_hi,
  output logic [AddrWidth-1:0]   o_target
);

  logic [AddrWidth-1:0] w_br_off;
  logic [AddrWidth-1:0] w_jmp_off;

  // Offsets are in halfwords: sign-extend, shift by one, keep the low AddrWidth bits.
  assign w_br_off  = AddrWidth'({{AddrWidth{i_imm_br[BrImmWidth-1]}}, i_imm_br, 1'b0});
  assign w_jmp_off = AddrWidth'({{AddrWidth{i_imm_jmp[JmpImmWidth-1]}}, i_imm_jmp, 1'b0});

  always_comb begin
    o_target = i_base + AddrWidth'(InstBytes);
    case (i_sel)
      PC_SEQ: o_target = i_base + AddrWidth'(InstBytes);
      PC_BR:  o_target = i_base + w_br_off;
      PC_JMP: o_target = i_base + w_jmp_off;
      PC_REG: o_target = {i_reg_hi, 1'b0};
    endcase
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch-front-end PC sequencer: single outstanding imem request, one-entry output
// register, redirect handling with drop of stale in-flight responses.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int                   AddrWidth   = 10,
  parameter int                   DataWidth   = 32,
  parameter int                   InstBytes   = 4,
  parameter int                   BrImmWidth  = 14,
  parameter int                   JmpImmWidth = 24,
  parameter logic [AddrWidth-1:0] ResetPc     = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   fetch_req,
  output logic [AddrWidth-1:0]   fetch_addr,
  input  logic                   fetch_ack,
  input  logic [DataWidth-1:0]   fetch_rdata,
  input  logic                   stall,
  output logic                   inst_valid,
  output logic [AddrWidth-1:0]   inst_pc,
  output logic [DataWidth-1:0]   inst_data,
  input  logic                   redirect_valid,
  input  logic [1:0]             pc_select,
  input  logic [AddrWidth-1:0]   redirect_base,
  input  logic [BrImmWidth-1:0]  imm_br,
  input  logic [JmpImmWidth-1:0] imm_jmp,
  input  logic [DataWidth-1:0]   reg_target
);

  fetch_state_e         r_state;
  logic                 r_flush_pending;
  logic [AddrWidth-1:0] r_pc;
  logic                 r_fetch_req;
  logic [AddrWidth-1:0] r_fetch_addr;
  logic                 r_inst_valid;
  logic [AddrWidth-1:0] r_inst_pc;
  logic [DataWidth-1:0] r_inst_data;

  logic [AddrWidth-1:0] w_target;
  logic [AddrWidth-1:0] w_next_seq;
  logic                 w_room;
  logic                 w_capture;
  logic                 w_unused_reg;

  // Only the PC-sized, halfword-aligned part of the register target matters.
  assign w_unused_reg = ^{reg_target[DataWidth-1:AddrWidth], reg_target[0]};

  pc_target_calc #(
    .AddrWidth   (AddrWidth),
    .InstBytes   (InstBytes),
    .BrImmWidth  (BrImmWidth),
    .JmpImmWidth (JmpImmWidth)
  ) u_target (
    .i_sel     (pc_sel_e'(pc_select)),
    .i_base    (redirect_base),
    .i_imm_br  (imm_br),
    .i_imm_jmp (imm_jmp),
    .i_reg_hi  (reg_target[AddrWidth-1:1]),
    .o_target  (w_target)
  );

  assign w_next_seq = r_fetch_addr + AddrWidth'(InstBytes);
  // Output register can take new data if it is empty or decode consumes it this cycle.
  assign w_room     = !r_inst_valid || !stall;
  // A response is kept only if it is current and has somewhere to go; a response that
  // arrives while the output is full and stalled is dropped and refetched later.
  assign w_capture  = (r_state == WAIT) && fetch_ack && !r_flush_pending &&
                      !redirect_valid && w_room;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= RESET;
      r_flush_pending <= 1'b0;
      r_pc            <= ResetPc;
      r_fetch_req     <= 1'b0;
      r_fetch_addr    <= ResetPc;
      r_inst_valid    <= 1'b0;
      r_inst_pc       <= '0;
      r_inst_data     <= '0;
    end else begin
      if (w_capture) begin
        r_inst_valid <= 1'b1;
        r_inst_pc    <= r_fetch_addr;
        r_inst_data  <= fetch_rdata;
      end else if (redirect_valid || !stall) begin
        r_inst_valid <= 1'b0;
      end

      if (redirect_valid)
        r_pc <= w_target;
      else if (w_capture)
        r_pc <= w_next_seq;

      unique case (r_state)
        RESET: r_state <= ISSUE;
        ISSUE: begin
          if (!redirect_valid && w_room) begin
            r_state      <= WAIT;
            r_fetch_req  <= 1'b1;
            r_fetch_addr <= r_pc;
          end
        end
        WAIT: begin
          if (fetch_ack) begin
            r_flush_pending <= 1'b0;
            if (w_capture && !stall) begin
              r_fetch_addr <= w_next_seq;
            end else begin
              r_state     <= ISSUE;
              r_fetch_req <= 1'b0;
            end
          end else if (redirect_valid) begin
            // Request stays on the bus until acked; its response is discarded.
            r_flush_pending <= 1'b1;
          end
        end
        default: r_state <= RESET;
      endcase
    end
  end

  assign fetch_req  = r_fetch_req;
  assign fetch_addr = r_fetch_addr;
  assign inst_valid = r_inst_valid;
  assign inst_pc    = r_inst_pc;
  assign inst_data  = r_inst_data;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed sequences, redirect target table, random run vs stream model.
module tb_fetch_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_rdata;
  logic        stall;
  logic        inst_valid;
  logic [9:0]  inst_pc;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [1:0]  pc_select;
  logic [9:0]  redirect_base;
  logic [13:0] imm_br;
  logic [23:0] imm_jmp;
  logic [31:0] reg_target;

  fetch_pc_sequencer #(
    .AddrWidth(10), .DataWidth(32), .InstBytes(4),
    .BrImmWidth(14), .JmpImmWidth(24), .ResetPc(10'h000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .stall(stall),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data),
    .redirect_valid(redirect_valid), .pc_select(pc_select),
    .redirect_base(redirect_base), .imm_br(imm_br), .imm_jmp(imm_jmp),
    .reg_target(reg_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] memf(input int a);
    return 32'hC0DE_0000 + 32'(a & 1023);
  endfunction

  // Target rule in plain integer arithmetic, modulo the 1 KiB address space.
  function automatic int tgt(input logic [1:0] sel, input int base, input logic [13:0] ib,
                             input logic [23:0] ij, input logic [31:0] rg);
    int r;
    case (sel)
      2'd0:    r = base + 4;
      2'd1:    r = base + 2 * int'($signed(ib));
      2'd2:    r = base + 2 * int'($signed(ij));
      default: r = int'(rg & 32'h3FE);
    endcase
    return r & 1023;
  endfunction

  // Imem responder state and stream-model state.
  int   lat = 0;
  bit   lat_rand = 0;
  int   wcnt = 0;
  bit   model_on = 0;
  int   exp_next = 0;
  int   n_deliv = 0;
  logic p_valid, p_stall, p_redir, p_req, p_ack;
  logic [9:0] p_addr, p_pc, p_base;
  logic [31:0] p_data, p_rg;
  logic [1:0] p_sel;
  logic [13:0] p_ib;
  logic [23:0] p_ij;

  // Called just after a rising edge: drive the memory, advance one cycle, check the model.
  task automatic tick();
    if (fetch_req) begin
      if (wcnt == 0) begin
        fetch_ack   = 1'b1;
        fetch_rdata = memf(int'(fetch_addr));
        wcnt = lat_rand ? int'($urandom_range(3, 0)) : lat;
      end else begin
        fetch_ack = 1'b0;
        wcnt--;
      end
    end else begin
      fetch_ack   = 1'b0;
      fetch_rdata = 32'h0;
    end
    p_valid = inst_valid; p_stall = stall; p_redir = redirect_valid;
    p_req = fetch_req; p_ack = fetch_ack; p_addr = fetch_addr;
    p_pc = inst_pc; p_data = inst_data;
    p_sel = pc_select; p_base = redirect_base; p_ib = imm_br; p_ij = imm_jmp; p_rg = reg_target;
    @(posedge clk); #1;
    if (model_on) begin
      if (p_redir) begin
        chk("redirect_clears_valid", inst_valid, 0);
        exp_next = tgt(p_sel, int'(p_base), p_ib, p_ij, p_rg);
      end else if (p_valid && p_stall) begin
        chk("stall_hold_valid", inst_valid, 1);
        chk("stall_hold_pc", inst_pc, p_pc);
        chk("stall_hold_data", inst_data, p_data);
      end else if (inst_valid) begin
        chk("stream_pc", inst_pc, exp_next);
        chk("stream_data", inst_data, memf(exp_next));
        exp_next = (exp_next + 4) & 1023;
        n_deliv++;
      end
      if (p_req && !p_ack) begin
        chk("req_held", fetch_req, 1);
        chk("addr_held", fetch_addr, p_addr);
      end
    end
  endtask

  task automatic settle();
    stall = 1'b1; redirect_valid = 1'b0; lat = 0; lat_rand = 0;
    repeat (10) tick();
    chk("settle_idle", fetch_req, 0);
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [9:0]  base;
    logic [13:0] ib;
    logic [23:0] ij;
    logic [31:0] rg;
    logic [9:0]  exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{2'd0, 10'h3FC, 14'h0000, 24'h000000, 32'h0000_0000, 10'h000};
    tbl[1] = '{2'd1, 10'h040, 14'h3FF8, 24'h000000, 32'h0000_0000, 10'h030};
    tbl[2] = '{2'd1, 10'h3F0, 14'h0010, 24'h000000, 32'h0000_0000, 10'h010};
    tbl[3] = '{2'd1, 10'h000, 14'h1FFF, 24'h000000, 32'h0000_0000, 10'h3FE};
    tbl[4] = '{2'd1, 10'h004, 14'h2000, 24'h000000, 32'h0000_0000, 10'h004};
    tbl[5] = '{2'd2, 10'h008, 14'h0000, 24'h000020, 32'h0000_0000, 10'h048};
    tbl[6] = '{2'd2, 10'h100, 14'h0000, 24'hFFFFFF, 32'h0000_0000, 10'h0FE};
    tbl[7] = '{2'd3, 10'h000, 14'h0000, 24'h000000, 32'h0001_0123, 10'h122};
    tbl[8] = '{2'd3, 10'h000, 14'h0000, 24'h000000, 32'hFFFF_FFFF, 10'h3FE};
    tbl[9] = '{2'd0, 10'h012, 14'h0000, 24'h000000, 32'h0000_0000, 10'h016};

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; pc_select = 2'd0;
    redirect_base = '0; imm_br = '0; imm_jmp = '0; reg_target = '0;
    fetch_ack = 1'b0; fetch_rdata = '0;

    // Reset values and first request timing.
    @(posedge clk); #1;
    chk("rst_req", fetch_req, 0);
    chk("rst_addr", fetch_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_data", inst_data, 0);
    rst_n = 1'b1;
    tick();
    chk("req_low_first_cycle", fetch_req, 0);
    tick();
    chk("req_rises_second_cycle", fetch_req, 1);
    chk("first_addr", fetch_addr, 0);

    // Zero-wait streaming.
    model_on = 1; exp_next = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("stream_addr", fetch_addr, 10'(4 * k));
      chk("stream_valid", inst_valid, 1);
      chk("stream_inst_pc", inst_pc, 10'(4 * (k - 1)));
    end

    // Stall for 4 cycles with a full output register.
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_frozen_pc", inst_pc, 10'h00C);
      chk("stall_no_req", fetch_req, 0);
    end
    stall = 1'b0;
    tick();
    chk("resume_addr", fetch_addr, 10'h010);
    chk("resume_req", fetch_req, 1);
    tick();
    chk("resume_inst_pc", inst_pc, 10'h010);

    // Redirect target table, each applied with no request outstanding.
    settle();
    for (int i = 0; i < 10; i++) begin
      redirect_valid = 1'b1; pc_select = tbl[i].sel; redirect_base = tbl[i].base;
      imm_br = tbl[i].ib; imm_jmp = tbl[i].ij; reg_target = tbl[i].rg;
      tick();
      redirect_valid = 1'b0;
      chk("tbl_no_req_at_redirect", fetch_req, 0);
      tick();
      chk("tbl_req", fetch_req, 1);
      chk("tbl_addr", fetch_addr, tbl[i].exp);
      tick();
      chk("tbl_inst_pc", inst_pc, tbl[i].exp);
    end

    // Jump redirect while a request to 0x10 waits for its ack.
    stall = 1'b0; redirect_valid = 1'b1; pc_select = 2'd3; reg_target = 32'h10;
    tick();
    redirect_valid = 1'b0;
    wcnt = 3; lat = 0;
    tick();
    chk("jmp_req_0x10", fetch_addr, 10'h010);
    tick();
    redirect_valid = 1'b1; pc_select = 2'd2; redirect_base = 10'h008; imm_jmp = 24'h20;
    tick();
    redirect_valid = 1'b0;
    chk("jmp_addr_held", fetch_addr, 10'h010);
    tick();
    tick();
    chk("jmp_stale_dropped", inst_valid, 0);
    chk("jmp_req_drops", fetch_req, 0);
    tick();
    chk("jmp_target_req", fetch_req, 1);
    chk("jmp_target_addr", fetch_addr, 10'h048);
    tick();
    chk("jmp_target_valid", inst_valid, 1);
    chk("jmp_target_pc", inst_pc, 10'h048);

    // Asynchronous reset with a request outstanding and an ack on the bus.
    model_on = 0;
    chk("pre_reset_req", fetch_req, 1);
    fetch_ack = 1'b1; fetch_rdata = memf(int'(fetch_addr));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", fetch_req, 0);
    chk("async_rst_addr", fetch_addr, 0);
    chk("async_rst_valid", inst_valid, 0);
    chk("async_rst_pc", inst_pc, 0);
    chk("async_rst_data", inst_data, 0);
    @(posedge clk); #1;
    chk("rst_held_req", fetch_req, 0);
    fetch_ack = 1'b0; rst_n = 1'b1; wcnt = 0; lat = 0;
    tick();
    tick();
    chk("restart_req", fetch_req, 1);
    chk("restart_addr", fetch_addr, 0);

    // Random traffic against the instruction-stream model.
    model_on = 1; exp_next = 0; n_deliv = 0; lat_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(9, 0) < 3);
      redirect_valid = ($urandom_range(19, 0) == 0);
      pc_select      = 2'($urandom_range(3, 0));
      redirect_base  = 10'($urandom);
      imm_br         = 14'($urandom);
      imm_jmp        = 24'($urandom);
      reg_target     = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    chk("random_progress", (n_deliv > 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Parametrised program-counter sequencer for the core's fetch front end. Holds the architectural fetch PC, issues instruction-memory requests over a req/ack handshake, and computes redirect targets: sequential, PC-relative branch/jump, or register-indirect. It buffers fetched instructions in a one-entry output register under decode stall, and discards in-flight fetches made stale by a redirect.

## Interface
- AddrWidth, 10, PC and fetch-address width
- DataWidth, 32, instruction and register width
- InstBytes, 4, sequential PC increment
- BrImmWidth, 14, conditional-branch immediate width
- JmpImmWidth, 24, jump immediate width
- ResetPc, 0, first fetch address after reset

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_req  out  1  instruction-memory request
- fetch_addr  out  AddrWidth  request address; stable while fetch_req && !fetch_ack
- fetch_ack  in  1  request accepted; fetch_rdata valid this cycle
- fetch_rdata  in  DataWidth  returned instruction
- stall  in  1  decode cannot accept; output register holds
- inst_valid  out  1  output register holds a valid instruction
- inst_pc  out  AddrWidth  address of inst_data
- inst_data  out  DataWidth  fetched instruction
- redirect_valid  in  1  control transfer resolved this cycle
- pc_select  in  2  00 base+InstBytes, 01 branch, 10 jump, 11 register
- redirect_base  in  AddrWidth  PC of the redirecting instruction
- imm_br  in  BrImmWidth  branch offset in halfwords
- imm_jmp  in  JmpImmWidth  jump offset in halfwords
- reg_target  in  DataWidth  register-indirect target

## Operation
- FSM states:
  - RESET: one cycle after rst_n release → ISSUE.
  - ISSUE: fetch_req=0. Go to WAIT and raise fetch_req when the output register is empty or consumed this cycle (stall==0).
  - WAIT: fetch_req=1.
    - On fetch_ack with no flush pending and no redirect: capture {pc, rdata} into the output register and set pc += InstBytes. If the launch condition also holds, stay in WAIT with the next address; otherwise go to ISSUE.
    - On fetch_ack with flush pending or a same-cycle redirect: drop the response and go to ISSUE.
- Target arithmetic, all modulo 2^AddrWidth:
  - 01: base + (sext(imm_br) << 1).
  - 10: base + (sext(imm_jmp) << 1).
  - 11: reg_target[AddrWidth-1:0] with bit 0 forced to 0.
- Redirect:
  - pc ← target.
  - inst_valid cleared the same edge, even under stall.
  - If a request is outstanding without ack, set flush_pending. The outstanding request is never withdrawn: fetch_addr is held until ack, then the response is dropped.
  - Redirects in back-to-back cycles: the last one wins.
- Output register:
  - Cleared when stall==0 and nothing new is captured.
  - Holds its contents while stall==1.
- At most one request is ever in flight, so a capture never overwrites unconsumed data.

## Timing
- Reset values: fetch_req=0, fetch_addr=ResetPc, inst_valid=0, inst_pc=0, inst_data=0, flush_pending=0, state=RESET.
- fetch_req first rises in the second cycle after rst_n release.
- Latency: fetch_ack edge → inst_valid on the next cycle.
- Zero-wait ack with stall=0 gives one instruction per cycle.
- Redirect at edge N: the first request at the target rises at N+1 if no request is outstanding. Otherwise it rises at ack+1, after the drop.
- stall and redirect in the same cycle: the redirect takes priority and the output is cleared.
- rst_n low mid-transaction: immediate return to reset values; the pending ack is ignored.

## Structure
- Shared package holds:
  - pc_select encodings: PC_SEQ, PC_BR, PC_JMP, PC_REG.
  - FSM state enum: RESET, ISSUE, WAIT.
- Sub-module pc_target_calc: combinational target computation from pc_select, base, immediates and reg_target.

## Test plan
- Reset release, ack every cycle, stall=0 → fetch_addr 0,4,8,12 on consecutive cycles; inst_pc follows one cycle later; inst_data matches memory.
- Branch redirect: base=0x40, imm_br=-8, no request outstanding → next fetch_addr=0x30; no inst_valid for stale addresses.
- Jump redirect while a request to 0x10 waits 3 cycles: imm_jmp=0x20, base=0x08 → response from 0x10 dropped; next fetch_addr=0x48.
- Register jump: reg_target=0x1_0123 with AddrWidth=10 → fetch_addr=0x122.
- Stall held 4 cycles with inst_valid=1 → inst_pc/inst_data frozen and no new request after the in-flight one. Release → resumes with the next sequential address.
- rst_n pulsed low while fetch_req=1 → outputs return to reset values asynchronously; fetching restarts at ResetPc.
